// File: rtl/ex_mem_skidreg.sv
// EX/MEM two-entry pipeline buffer (head + skid) with registered EX_Ready.
// Optional flush support is compiled in when EX_MEM_FLUSH_EN is defined.
module ex_mem_skidreg (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_Valid,
    output logic        EX_Ready,
    input  logic        EX_WRegEn,
    input  logic        EX_WMemEn,
    input  logic [63:0] EX_ALUout,
    input  logic [63:0] EX_R2out,
    input  logic [4:0]  EX_WReg1,
    input  logic        Flush,
    output logic        MEM_Valid,
    input  logic        MEM_Ready,
    output logic        MEM_WRegEn,
    output logic        MEM_WMemEn,
    output logic [63:0] MEM_ALUout,
    output logic [63:0] MEM_StoreData,
    output logic [4:0]  MEM_WReg1,
    output logic [1:0]  MEM_Count,
    output logic [31:0] HZ_PendMask
);

    // state | meaning
    // EMPTY | no entry held
    // ONE   | head holds the oldest entry
    // FULL  | head and skid both hold entries, EX is stalled
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state, next_state;
    logic           head_valid, skid_valid;
    logic [134:0]   head_q, skid_q;
    logic [134:0]   ex_payload;
    logic           head_wregen, head_wmemen;
    logic           in_fire, out_fire;
    logic           do_flush;

`ifdef EX_MEM_FLUSH_EN
    assign do_flush = Flush;
`else
    logic unused_flush;
    assign unused_flush = Flush;
    assign do_flush     = 1'b0;
`endif

    assign ex_payload = {EX_WRegEn, EX_WMemEn, EX_ALUout, EX_R2out, EX_WReg1};
    assign in_fire    = EX_Valid & EX_Ready;
    assign out_fire   = MEM_Valid & MEM_Ready;

    assign {head_wregen, head_wmemen, MEM_ALUout, MEM_StoreData, MEM_WReg1} = head_q;
    assign MEM_Valid  = head_valid;
    assign MEM_WRegEn = head_valid & head_wregen;
    assign MEM_WMemEn = head_valid & head_wmemen;
    assign MEM_Count  = state;

    always_comb begin
        next_state = state;
        if (do_flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) next_state = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      next_state = FULL;
                    else if (!in_fire && out_fire) next_state = EMPTY;
                end
                FULL:    if (out_fire) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            EX_Ready   <= 1'b1;
        end else begin
            state      <= next_state;
            head_valid <= (next_state != EMPTY);
            skid_valid <= (next_state == FULL);
            EX_Ready   <= (next_state != FULL);
            if (!do_flush) begin
                case (state)
                    EMPTY: if (in_fire) head_q <= ex_payload;
                    ONE: begin
                        if (in_fire && out_fire) head_q <= ex_payload;
                        else if (in_fire)        skid_q <= ex_payload;
                    end
                    FULL:    if (out_fire) head_q <= skid_q;
                    default: ;
                endcase
            end
        end
    end

    // Pending-write mask over both held entries, for ID-stage hazard checks.
    always_comb begin
        HZ_PendMask = '0;
        if (head_valid && head_q[134]) HZ_PendMask[head_q[4:0]] = 1'b1;
        if (skid_valid && skid_q[134]) HZ_PendMask[skid_q[4:0]] = 1'b1;
    end

endmodule

// File: tb/tb_ex_mem_skidreg.sv
// Directed self-checking bench for ex_mem_skidreg; inputs change on negedge,
// outputs are checked on the following negedge.
module tb_ex_mem_skidreg;

    logic        clk = 1'b0;
    logic        reset;
    logic        EX_Valid, EX_Ready, EX_WRegEn, EX_WMemEn;
    logic [63:0] EX_ALUout, EX_R2out;
    logic [4:0]  EX_WReg1;
    logic        Flush;
    logic        MEM_Valid, MEM_Ready, MEM_WRegEn, MEM_WMemEn;
    logic [63:0] MEM_ALUout, MEM_StoreData;
    logic [4:0]  MEM_WReg1;
    logic [1:0]  MEM_Count;
    logic [31:0] HZ_PendMask;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_skidreg dut (
        .clk(clk), .reset(reset),
        .EX_Valid(EX_Valid), .EX_Ready(EX_Ready),
        .EX_WRegEn(EX_WRegEn), .EX_WMemEn(EX_WMemEn),
        .EX_ALUout(EX_ALUout), .EX_R2out(EX_R2out), .EX_WReg1(EX_WReg1),
        .Flush(Flush),
        .MEM_Valid(MEM_Valid), .MEM_Ready(MEM_Ready),
        .MEM_WRegEn(MEM_WRegEn), .MEM_WMemEn(MEM_WMemEn),
        .MEM_ALUout(MEM_ALUout), .MEM_StoreData(MEM_StoreData),
        .MEM_WReg1(MEM_WReg1), .MEM_Count(MEM_Count),
        .HZ_PendMask(HZ_PendMask)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic wr, input logic wm,
                         input logic [63:0] alu, input logic [63:0] r2,
                         input logic [4:0] rd);
        EX_Valid  = v;
        EX_WRegEn = wr;
        EX_WMemEn = wm;
        EX_ALUout = alu;
        EX_R2out  = r2;
        EX_WReg1  = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MEM_Ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 64'd55, 64'd66, 5'd7);
        tick(); tick();
        vectors++; if (MEM_Count !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", MEM_Count); end
        vectors++; if (MEM_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", MEM_Valid); end
        vectors++; if (EX_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b want 1", EX_Ready); end
        vectors++; if (HZ_PendMask !== 32'h0) begin miscompares++; $display("FAIL reset_mask: got %h want 0", HZ_PendMask); end
        vectors++; if (MEM_ALUout !== 64'd0 || MEM_WRegEn !== 1'b0) begin miscompares++; $display("FAIL reset_outs: alu %h wregen %0b want 0/0", MEM_ALUout, MEM_WRegEn); end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        tick();
    endtask

    task automatic test_streaming();
        MEM_Ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'd1, 64'd11, 5'd1);
        tick();
        vectors++; if (MEM_ALUout !== 64'd1 || MEM_Valid !== 1'b1) begin miscompares++; $display("FAIL stream_1: alu %0d valid %0b want 1/1", MEM_ALUout, MEM_Valid); end
        drive(1'b1, 1'b1, 1'b0, 64'd2, 64'd12, 5'd2);
        tick();
        vectors++; if (MEM_ALUout !== 64'd2 || MEM_Count !== 2'd1) begin miscompares++; $display("FAIL stream_2: alu %0d count %0d want 2/1", MEM_ALUout, MEM_Count); end
        drive(1'b1, 1'b1, 1'b0, 64'd3, 64'd13, 5'd3);
        tick();
        vectors++; if (MEM_ALUout !== 64'd3 || MEM_Count !== 2'd1) begin miscompares++; $display("FAIL stream_3: alu %0d count %0d want 3/1", MEM_ALUout, MEM_Count); end
        vectors++; if (MEM_StoreData !== 64'd13 || MEM_WReg1 !== 5'd3) begin miscompares++; $display("FAIL stream_3_fields: sd %0d rd %0d want 13/3", MEM_StoreData, MEM_WReg1); end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        tick();
        vectors++; if (MEM_Count !== 2'd0 || MEM_Valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: count %0d valid %0b want 0/0", MEM_Count, MEM_Valid); end
        vectors++; if (MEM_WRegEn !== 1'b0 || MEM_ALUout !== 64'd3) begin miscompares++; $display("FAIL stream_gate: wregen %0b alu %0d want 0/3", MEM_WRegEn, MEM_ALUout); end
    endtask

    task automatic test_backpressure();
        MEM_Ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 64'hA, 64'h1A, 5'd3);
        tick();
        vectors++; if (MEM_Count !== 2'd1 || EX_Ready !== 1'b1) begin miscompares++; $display("FAIL bp_a: count %0d ready %0b want 1/1", MEM_Count, EX_Ready); end
        drive(1'b1, 1'b0, 1'b1, 64'hB, 64'h1B, 5'd4);
        tick();
        vectors++; if (MEM_Count !== 2'd2 || EX_Ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: count %0d ready %0b want 2/0", MEM_Count, EX_Ready); end
        vectors++; if (MEM_ALUout !== 64'hA || MEM_WMemEn !== 1'b1) begin miscompares++; $display("FAIL bp_head_a: alu %h wmemen %0b want a/1", MEM_ALUout, MEM_WMemEn); end
        drive(1'b1, 1'b0, 1'b1, 64'hC, 64'h1C, 5'd5);
        tick();
        vectors++; if (MEM_Count !== 2'd2 || MEM_ALUout !== 64'hA || MEM_StoreData !== 64'h1A) begin miscompares++; $display("FAIL bp_hold: count %0d alu %h sd %h want 2/a/1a", MEM_Count, MEM_ALUout, MEM_StoreData); end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        MEM_Ready = 1'b1;
        tick();
        vectors++; if (MEM_ALUout !== 64'hB || MEM_StoreData !== 64'h1B || MEM_WReg1 !== 5'd4) begin miscompares++; $display("FAIL bp_head_b: alu %h sd %h rd %0d want b/1b/4", MEM_ALUout, MEM_StoreData, MEM_WReg1); end
        vectors++; if (MEM_Count !== 2'd1 || EX_Ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_a: count %0d ready %0b want 1/1", MEM_Count, EX_Ready); end
        tick();
        vectors++; if (MEM_Count !== 2'd0 || MEM_Valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: count %0d valid %0b want 0/0", MEM_Count, MEM_Valid); end
    endtask

    task automatic test_hazard();
        MEM_Ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h50, 64'h0, 5'd5);
        tick();
        vectors++; if (HZ_PendMask !== 32'h0000_0020) begin miscompares++; $display("FAIL hz_one: got %h want 00000020", HZ_PendMask); end
        drive(1'b1, 1'b0, 1'b1, 64'h90, 64'h0, 5'd9);
        tick();
        vectors++; if (HZ_PendMask !== 32'h0000_0020 || MEM_Count !== 2'd2) begin miscompares++; $display("FAIL hz_two: mask %h count %0d want 00000020/2", HZ_PendMask, MEM_Count); end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        MEM_Ready = 1'b1;
        tick();
        vectors++; if (HZ_PendMask !== 32'h0 || MEM_WRegEn !== 1'b0 || MEM_WMemEn !== 1'b1) begin miscompares++; $display("FAIL hz_drain1: mask %h wr %0b wm %0b want 0/0/1", HZ_PendMask, MEM_WRegEn, MEM_WMemEn); end
        tick();
        MEM_Ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h1, 64'h0, 5'd5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 64'h2, 64'h0, 5'd7);
        tick();
        vectors++; if (HZ_PendMask !== 32'h0000_00A0) begin miscompares++; $display("FAIL hz_both: got %h want 000000a0", HZ_PendMask); end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        MEM_Ready = 1'b1;
        tick(); tick();
        vectors++; if (HZ_PendMask !== 32'h0 || MEM_Count !== 2'd0) begin miscompares++; $display("FAIL hz_clear: mask %h count %0d want 0/0", HZ_PendMask, MEM_Count); end
    endtask

    task automatic test_simultaneous();
        MEM_Ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 5'd1);
        tick();
        vectors++; if (MEM_ALUout !== 64'h100 || MEM_Count !== 2'd1) begin miscompares++; $display("FAIL sim_x: alu %h count %0d want 100/1", MEM_ALUout, MEM_Count); end
        drive(1'b1, 1'b1, 1'b0, 64'h200, 64'h0, 5'd2);
        tick();
        vectors++; if (MEM_ALUout !== 64'h200 || MEM_Count !== 2'd1 || EX_Ready !== 1'b1) begin miscompares++; $display("FAIL sim_y: alu %h count %0d ready %0b want 200/1/1", MEM_ALUout, MEM_Count, EX_Ready); end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        tick();
    endtask

    task automatic test_flush();
        MEM_Ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'hF1, 64'h0, 5'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 64'hF2, 64'h0, 5'd2);
        tick();
        Flush = 1'b1;
        MEM_Ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'hD0, 64'h0, 5'd3);
        tick();
        Flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
`ifdef EX_MEM_FLUSH_EN
        vectors++; if (MEM_Count !== 2'd0 || MEM_Valid !== 1'b0 || EX_Ready !== 1'b1) begin miscompares++; $display("FAIL flush_empty: count %0d valid %0b ready %0b want 0/0/1", MEM_Count, MEM_Valid, EX_Ready); end
        tick();
        vectors++; if (MEM_Count !== 2'd0 || MEM_Valid !== 1'b0 || HZ_PendMask !== 32'h0) begin miscompares++; $display("FAIL flush_noinput: count %0d valid %0b mask %h want 0/0/0", MEM_Count, MEM_Valid, HZ_PendMask); end
`else
        vectors++; if (MEM_Count !== 2'd1 || MEM_ALUout !== 64'hF2) begin miscompares++; $display("FAIL flush_ignored: count %0d alu %h want 1/f2", MEM_Count, MEM_ALUout); end
        tick();
        vectors++; if (MEM_Count !== 2'd0 || MEM_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_ignored_drain: count %0d valid %0b want 0/0", MEM_Count, MEM_Valid); end
`endif
    endtask

    task automatic test_reset_mid_full();
        MEM_Ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 64'hE1, 64'hE2, 5'd8);
        tick();
        drive(1'b1, 1'b1, 1'b1, 64'hE3, 64'hE4, 5'd9);
        tick();
        vectors++; if (MEM_Count !== 2'd2) begin miscompares++; $display("FAIL rmf_fill: count %0d want 2", MEM_Count); end
        reset = 1'b1;
        Flush = 1'b1;
        MEM_Ready = 1'b1;
        tick();
        reset = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        vectors++; if (MEM_Count !== 2'd0 || MEM_Valid !== 1'b0 || EX_Ready !== 1'b1) begin miscompares++; $display("FAIL rmf_state: count %0d valid %0b ready %0b want 0/0/1", MEM_Count, MEM_Valid, EX_Ready); end
        vectors++; if (MEM_ALUout !== 64'd0 || MEM_StoreData !== 64'd0 || MEM_WReg1 !== 5'd0 || HZ_PendMask !== 32'h0) begin miscompares++; $display("FAIL rmf_clear: alu %h sd %h rd %0d mask %h want all 0", MEM_ALUout, MEM_StoreData, MEM_WReg1, HZ_PendMask); end
        tick();
        vectors++; if (MEM_Count !== 2'd0) begin miscompares++; $display("FAIL rmf_stay: count %0d want 0", MEM_Count); end
    endtask

    initial begin
        reset = 1'b1;
        Flush = 1'b0;
        MEM_Ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_hazard();
        test_simultaneous();
        test_flush();
        test_reset_mid_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
